// File: rtl/leiwand_rv32_core.sv
// ============================================================================
//  Module   : leiwand_rv32_core
//  Brief    : Multi-cycle, non-pipelined RV32I core with one unified
//             valid/ready memory port and a memory-mapped debug LED.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leiwand_rv32_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] LED_ADDR = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data_cpu_in,
   output logic [31:0] mem_data_cpu_out,
   output logic [3:0]  mem_wen,
   output logic        debug_led
);

   typedef enum logic [2:0] {
      STAGE_INSTR_FETCH       = 3'd0,
      STAGE_INSTR_DECODE      = 3'd1,
      STAGE_INSTR_ALU_PREPARE = 3'd2,
      STAGE_INSTR_EXECUTE     = 3'd3,
      STAGE_INSTR_MEM         = 3'd4,
      STAGE_INSTR_WRITEBACK   = 3'd5
   } cpu_stage_t;

   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_reg    = 7'b0110011;

   // Debug-visible architectural state
   cpu_stage_t  cpu_stage;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic [31:0] x [0:31];

   // Per-instruction working registers
   logic [31:0] r_rs1_val;
   logic [31:0] r_rs2_val;
   logic [31:0] r_imm;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [31:0] r_alu_result;
   logic [31:0] r_next_pc;
   logic [31:0] r_load_data;

   // Instruction fields
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [2:0]  w_funct3;
   logic        w_alt;
   assign w_opcode = instruction[6:0];
   assign w_rd     = instruction[11:7];
   assign w_funct3 = instruction[14:12];
   assign w_rs1    = instruction[19:15];
   assign w_rs2    = instruction[24:20];
   assign w_alt    = instruction[30];

   logic w_is_load;
   logic w_is_store;
   logic w_led_store;
   logic [31:0] w_ea;
   assign w_is_load   = (w_opcode == c_op_load);
   assign w_is_store  = (w_opcode == c_op_store);
   // Effective address is stable from ALU_PREPARE onwards (operands latched in DECODE)
   assign w_ea        = r_rs1_val + r_imm;
   assign w_led_store = w_is_store && (w_ea == LED_ADDR);

   // Immediate generation by instruction format
   logic [31:0] w_imm;
   always_comb begin
      w_imm = {{20{instruction[31]}}, instruction[31:20]};
      case (w_opcode)
         c_op_lui, c_op_auipc: w_imm = {instruction[31:12], 12'd0};
         c_op_jal:    w_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                               instruction[20], instruction[30:21], 1'b0};
         c_op_branch: w_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                               instruction[30:25], instruction[11:8], 1'b0};
         c_op_store:  w_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         default:     w_imm = {{20{instruction[31]}}, instruction[31:20]};
      endcase
   end

   // ALU: SUB only exists for register-register ops; SRA/SRAI share bit 30
   logic [4:0]  w_shamt;
   logic [31:0] w_alu;
   assign w_shamt = r_op_b[4:0];
   always_comb begin
      w_alu = 32'd0;
      case (w_funct3)
         3'b000: w_alu = ((w_opcode == c_op_reg) && w_alt) ? (r_op_a - r_op_b) : (r_op_a + r_op_b);
         3'b001: w_alu = r_op_a << w_shamt;
         3'b010: w_alu = {31'd0, $signed(r_op_a) < $signed(r_op_b)};
         3'b011: w_alu = {31'd0, r_op_a < r_op_b};
         3'b100: w_alu = r_op_a ^ r_op_b;
         3'b101: w_alu = w_alt ? $unsigned($signed(r_op_a) >>> w_shamt) : (r_op_a >> w_shamt);
         3'b110: w_alu = r_op_a | r_op_b;
         default: w_alu = r_op_a & r_op_b;
      endcase
   end

   // Branch condition and next-PC selection
   logic        w_taken;
   logic [31:0] w_next_pc;
   always_comb begin
      w_taken = 1'b0;
      case (w_funct3)
         3'b000: w_taken = (r_rs1_val == r_rs2_val);
         3'b001: w_taken = (r_rs1_val != r_rs2_val);
         3'b100: w_taken = ($signed(r_rs1_val) <  $signed(r_rs2_val));
         3'b101: w_taken = ($signed(r_rs1_val) >= $signed(r_rs2_val));
         3'b110: w_taken = (r_rs1_val <  r_rs2_val);
         3'b111: w_taken = (r_rs1_val >= r_rs2_val);
         default: w_taken = 1'b0;
      endcase
      w_next_pc = pc + 32'd4;
      if ((w_opcode == c_op_jal) || ((w_opcode == c_op_branch) && w_taken))
         w_next_pc = pc + r_imm;
      else if (w_opcode == c_op_jalr)
         w_next_pc = w_ea & ~32'd1;
   end

   // Load lane extraction and sign/zero extension
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   always_comb begin
      case (w_ea[1:0])
         2'd0:    w_byte = mem_data_cpu_in[7:0];
         2'd1:    w_byte = mem_data_cpu_in[15:8];
         2'd2:    w_byte = mem_data_cpu_in[23:16];
         default: w_byte = mem_data_cpu_in[31:24];
      endcase
      w_half = w_ea[1] ? mem_data_cpu_in[31:16] : mem_data_cpu_in[15:0];
      case (w_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = mem_data_cpu_in;
      endcase
   end

   // Store lane enables with data replicated into every lane
   logic [3:0]  w_store_wen;
   logic [31:0] w_store_data;
   always_comb begin
      case (w_funct3[1:0])
         2'b00: begin
            w_store_wen  = 4'b0001 << w_ea[1:0];
            w_store_data = {4{r_rs2_val[7:0]}};
         end
         2'b01: begin
            w_store_wen  = 4'b0011 << {w_ea[1], 1'b0};
            w_store_data = {2{r_rs2_val[15:0]}};
         end
         default: begin
            w_store_wen  = 4'b1111;
            w_store_data = r_rs2_val;
         end
      endcase
   end

   // Register-file write value; pc still holds the current instruction here
   logic        w_rd_we;
   logic [31:0] w_wb;
   always_comb begin
      w_rd_we = 1'b1;
      w_wb    = r_alu_result;
      case (w_opcode)
         c_op_reg, c_op_imm:  w_wb = r_alu_result;
         c_op_load:           w_wb = r_load_data;
         c_op_lui:            w_wb = r_imm;
         c_op_auipc:          w_wb = pc + r_imm;
         c_op_jal, c_op_jalr: w_wb = pc + 32'd4;
         default:             w_rd_we = 1'b0;
      endcase
   end

   // Stage sequencer, register file and registered memory port
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_stage        <= STAGE_INSTR_FETCH;
         pc               <= RESET_PC;
         instruction      <= 32'd0;
         for (int i = 0; i < 32; i++) x[i] <= 32'd0;
         mem_valid        <= 1'b0;
         mem_wen          <= 4'd0;
         mem_addr         <= 32'd0;
         mem_data_cpu_out <= 32'd0;
         debug_led        <= 1'b0;
         r_rs1_val        <= 32'd0;
         r_rs2_val        <= 32'd0;
         r_imm            <= 32'd0;
         r_op_a           <= 32'd0;
         r_op_b           <= 32'd0;
         r_alu_result     <= 32'd0;
         r_next_pc        <= 32'd0;
         r_load_data      <= 32'd0;
      end else begin
         case (cpu_stage)
            STAGE_INSTR_FETCH: begin
               if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_addr  <= pc;
                  mem_wen   <= 4'd0;
               end else if (mem_ready) begin
                  instruction <= mem_data_cpu_in;
                  mem_valid   <= 1'b0;
                  cpu_stage   <= STAGE_INSTR_DECODE;
               end
            end
            STAGE_INSTR_DECODE: begin
               r_rs1_val <= (w_rs1 == 5'd0) ? 32'd0 : x[w_rs1];
               r_rs2_val <= (w_rs2 == 5'd0) ? 32'd0 : x[w_rs2];
               r_imm     <= w_imm;
               cpu_stage <= STAGE_INSTR_ALU_PREPARE;
            end
            STAGE_INSTR_ALU_PREPARE: begin
               r_op_a    <= r_rs1_val;
               r_op_b    <= (w_opcode == c_op_reg) ? r_rs2_val : r_imm;
               cpu_stage <= STAGE_INSTR_EXECUTE;
            end
            STAGE_INSTR_EXECUTE: begin
               r_alu_result <= w_alu;
               r_next_pc    <= w_next_pc;
               cpu_stage    <= (w_is_load || w_is_store) ? STAGE_INSTR_MEM : STAGE_INSTR_WRITEBACK;
            end
            STAGE_INSTR_MEM: begin
               if (w_led_store) begin
                  debug_led <= r_rs2_val[0];
                  cpu_stage <= STAGE_INSTR_WRITEBACK;
               end else if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_addr  <= {w_ea[31:2], 2'b00};
                  mem_wen   <= w_is_store ? w_store_wen : 4'd0;
                  if (w_is_store) mem_data_cpu_out <= w_store_data;
               end else if (mem_ready) begin
                  r_load_data <= w_load_data;
                  mem_valid   <= 1'b0;
                  mem_wen     <= 4'd0;
                  cpu_stage   <= STAGE_INSTR_WRITEBACK;
               end
            end
            STAGE_INSTR_WRITEBACK: begin
               if (w_rd_we && (w_rd != 5'd0)) x[w_rd] <= w_wb;
               pc        <= r_next_pc;
               cpu_stage <= STAGE_INSTR_FETCH;
            end
            default: cpu_stage <= STAGE_INSTR_FETCH;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_leiwand_rv32_core.sv
// ============================================================================
//  Module   : tb_leiwand_rv32_core
//  Brief    : Directed self-checking bench for leiwand_rv32_core with a
//             one-cycle-latency word memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leiwand_rv32_core;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_cpu_in;
   logic [31:0] mem_data_cpu_out;
   logic [3:0]  mem_wen;
   logic        debug_led;

   int checks   = 0;
   int failures = 0;

   logic        hold_ready = 1'b0;
   logic [31:0] prog [0:255];
   logic [31:0] mem  [0:255];
   logic [3:0]  sb_wen       = 4'd0;
   logic [31:0] sb_data      = 32'd0;
   logic        led_bus_seen = 1'b0;

   leiwand_rv32_core #(
      .RESET_PC (32'h0000_0000),
      .LED_ADDR (32'h8000_0000)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_valid        (mem_valid),
      .mem_ready        (mem_ready),
      .mem_addr         (mem_addr),
      .mem_data_cpu_in  (mem_data_cpu_in),
      .mem_data_cpu_out (mem_data_cpu_out),
      .mem_wen          (mem_wen),
      .debug_led        (debug_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: ready one cycle after valid, registered read data, byte writes
   always @(posedge clk) begin
      if (reset) begin
         mem_ready <= 1'b0;
         for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      end else if (mem_valid && !mem_ready && !hold_ready) begin
         mem_ready       <= 1'b1;
         mem_data_cpu_in <= mem[mem_addr[9:2]];
         if (mem_wen[0]) mem[mem_addr[9:2]][7:0]   <= mem_data_cpu_out[7:0];
         if (mem_wen[1]) mem[mem_addr[9:2]][15:8]  <= mem_data_cpu_out[15:8];
         if (mem_wen[2]) mem[mem_addr[9:2]][23:16] <= mem_data_cpu_out[23:16];
         if (mem_wen[3]) mem[mem_addr[9:2]][31:24] <= mem_data_cpu_out[31:24];
      end else begin
         mem_ready <= 1'b0;
      end
   end

   // Bus observers for the sb at 0x60 and the LED store at 0x6C
   always @(negedge clk) begin
      if (mem_valid && (mem_wen != 4'd0) && (dut.pc == 32'h60)) begin
         sb_wen  <= mem_wen;
         sb_data <= mem_data_cpu_out;
      end
      if (mem_valid && (dut.pc == 32'h6C) && (dut.cpu_stage != 3'd0))
         led_bus_seen <= 1'b1;
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_until(input logic [31:0] tpc, input logic [2:0] tstage,
                            input int budget, input string tag);
      int n;
      n = 0;
      while (!((dut.pc === tpc) && (3'(dut.cpu_stage) === tstage)) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check({"reach_", tag}, {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic wait_stage(input logic [2:0] tstage, input int budget, input string tag);
      int n;
      n = 0;
      while ((3'(dut.cpu_stage) !== tstage) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check({"stage_", tag}, {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic check_regs_zero(input string tag);
      logic [31:0] acc;
      acc = 32'd0;
      for (int i = 0; i < 32; i++) acc = acc | dut.x[i];
      check(tag, acc, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 256; i++) prog[i] = 32'd0;
      prog[0]  = enc_i(12'd5,   5'd0,  3'd0, 5'd1,  7'h13);   // addi x1,x0,5
      prog[1]  = enc_i(12'hFF9, 5'd1,  3'd0, 5'd2,  7'h13);   // addi x2,x1,-7
      prog[2]  = enc_u(20'h00001, 5'd4, 7'h17);               // auipc x4,1
      prog[3]  = enc_u(20'h12345, 5'd3, 7'h37);               // lui x3,0x12345
      prog[4]  = enc_i(12'd1,   5'd0,  3'd0, 5'd0,  7'h13);   // addi x0,x0,1
      prog[5]  = enc_i(12'd3,   5'd0,  3'd0, 5'd5,  7'h13);   // addi x5,x0,3
      prog[6]  = enc_i(12'd0,   5'd0,  3'd0, 5'd6,  7'h13);   // addi x6,x0,0
      prog[7]  = enc_i(12'd1,   5'd6,  3'd0, 5'd6,  7'h13);   // addi x6,x6,1
      prog[8]  = enc_i(12'hFFF, 5'd5,  3'd0, 5'd5,  7'h13);   // addi x5,x5,-1
      prog[9]  = enc_b(13'h1FF8, 5'd0, 5'd5, 3'd1);           // bne x5,x0,-8
      prog[10] = enc_j(21'd8, 5'd1);                          // jal x1,+8
      prog[11] = enc_i(12'd99,  5'd0,  3'd0, 5'd7,  7'h13);   // skipped
      prog[12] = enc_i(12'h041, 5'd0,  3'd0, 5'd8,  7'h13);   // addi x8,x0,0x41
      prog[13] = enc_i(12'd0,   5'd8,  3'd0, 5'd9,  7'h67);   // jalr x9,0(x8)
      prog[14] = enc_i(12'd77,  5'd0,  3'd0, 5'd7,  7'h13);   // skipped
      prog[15] = enc_i(12'd77,  5'd0,  3'd0, 5'd7,  7'h13);   // skipped
      prog[16] = enc_u(20'h80FF8, 5'd10, 7'h37);              // lui x10,0x80FF8
      prog[17] = enc_i(12'hF01, 5'd10, 3'd0, 5'd10, 7'h13);   // addi x10,x10,-255
      prog[18] = enc_i(12'h100, 5'd0,  3'd0, 5'd11, 7'h13);   // addi x11,x0,0x100
      prog[19] = enc_s(12'd0, 5'd10, 5'd11, 3'd2);            // sw x10,0(x11)
      prog[20] = enc_i(12'd1,   5'd11, 3'd0, 5'd12, 7'h03);   // lb  x12,1(x11)
      prog[21] = enc_i(12'd1,   5'd11, 3'd4, 5'd13, 7'h03);   // lbu x13,1(x11)
      prog[22] = enc_i(12'd2,   5'd11, 3'd1, 5'd14, 7'h03);   // lh  x14,2(x11)
      prog[23] = enc_i(12'd0,   5'd11, 3'd2, 5'd15, 7'h03);   // lw  x15,0(x11)
      prog[24] = enc_s(12'd3, 5'd10, 5'd11, 3'd0);            // sb x10,3(x11)
      prog[25] = enc_u(20'h80000, 5'd16, 7'h37);              // lui x16,0x80000
      prog[26] = enc_i(12'd1,   5'd0,  3'd0, 5'd17, 7'h13);   // addi x17,x0,1
      prog[27] = enc_s(12'd0, 5'd17, 5'd16, 3'd2);            // sw x17,0(x16) -> LED
      prog[28] = enc_s(12'd0, 5'd0,  5'd16, 3'd2);            // sw x0,0(x16)  -> LED
      prog[29] = enc_r(7'h20, 5'd17, 5'd2, 3'd0, 5'd18);      // sub  x18,x2,x17
      prog[30] = enc_i(12'h404, 5'd10, 3'd5, 5'd19, 7'h13);   // srai x19,x10,4
      prog[31] = enc_r(7'h00, 5'd2, 5'd17, 3'd3, 5'd20);      // sltu x20,x17,x2
      prog[32] = enc_r(7'h00, 5'd17, 5'd2, 3'd2, 5'd21);      // slt  x21,x2,x17
      prog[33] = enc_r(7'h00, 5'd17, 5'd2, 3'd3, 5'd22);      // sltu x22,x2,x17
      prog[34] = enc_j(21'd0, 5'd0);                          // jal x0,0

      repeat (3) @(negedge clk);
      check("rst_pc",        dut.pc, 32'h0);
      check("rst_stage",     {29'd0, 3'(dut.cpu_stage)}, 32'd0);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_mem_wen",   {28'd0, mem_wen}, 32'd0);
      check("rst_mem_addr",  mem_addr, 32'd0);
      check("rst_led",       {31'd0, debug_led}, 32'd0);
      check_regs_zero("rst_regs");
      reset = 1'b0;

      wait_stage(3'd2, 100, "prep0");
      check("prep_pc0", dut.pc, 32'h0);
      wait_stage(3'd3, 100, "exec0");
      wait_stage(3'd2, 100, "prep1");
      check("prep_pc1", dut.pc, 32'h4);

      run_until(32'h08, 3'd0, 200, "pc08");
      check("addi_x1", dut.x[1], 32'h0000_0005);
      check("addi_x2", dut.x[2], 32'hFFFF_FFFE);

      run_until(32'h70, 3'd0, 2000, "pc70");
      check("led_set",      {31'd0, debug_led}, 32'd1);
      check("led_no_bus",   {31'd0, led_bus_seen}, 32'd0);

      run_until(32'h88, 3'd0, 2000, "pc88");
      check("lui_x3",    dut.x[3], 32'h1234_5000);
      check("auipc_x4",  dut.x[4], 32'h0000_1008);
      check("x0_zero",   dut.x[0], 32'h0);
      check("loop_x5",   dut.x[5], 32'h0);
      check("loop_x6",   dut.x[6], 32'h3);
      check("skip_x7",   dut.x[7], 32'h0);
      check("jal_link",  dut.x[1], 32'h0000_002C);
      check("jalr_link", dut.x[9], 32'h0000_0038);
      check("sw_value",  dut.x[10], 32'h80FF_7F01);
      check("lb_101",    dut.x[12], 32'h0000_007F);
      check("lbu_101",   dut.x[13], 32'h0000_007F);
      check("lh_102",    dut.x[14], 32'hFFFF_80FF);
      check("lw_100",    dut.x[15], 32'h80FF_7F01);
      check("sb_wen",    {28'd0, sb_wen}, 32'h8);
      check("sb_data",   sb_data, 32'h0101_0101);
      check("sb_mem",    mem[64], 32'h01FF_7F01);
      check("led_clear", {31'd0, debug_led}, 32'd0);
      check("sub_x18",   dut.x[18], 32'hFFFF_FFFD);
      check("srai_x19",  dut.x[19], 32'hF80F_F7F0);
      check("sltu_x20",  dut.x[20], 32'h1);
      check("slt_x21",   dut.x[21], 32'h1);
      check("sltu_x22",  dut.x[22], 32'h0);

      // Restart, then abort a stalled load with reset
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run_until(32'h50, 3'd3, 2000, "lb_exec");
      hold_ready = 1'b1;
      run_until(32'h50, 3'd4, 50, "lb_mem");
      repeat (4) @(negedge clk);
      check("stall_valid", {31'd0, mem_valid}, 32'd1);
      check("stall_addr",  mem_addr, 32'h0000_0100);
      check("stall_x11",   dut.x[11], 32'h0000_0100);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_valid", {31'd0, mem_valid}, 32'd0);
      check("abort_pc",    dut.pc, 32'h0);
      check("abort_stage", {29'd0, 3'(dut.cpu_stage)}, 32'd0);
      check_regs_zero("abort_regs");
      hold_ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
